// File: rtl/bfly_twiddle_mul.sv
// Twiddle multiply after the 16-lane butterfly stage: capture, full-precision
// complex multiply by W_N^(lane*blk), then round/saturate back to the I/O width.
module bfly_twiddle_mul #(
   parameter int SIG     = 1,
   parameter int INT     = 3,
   parameter int FLT     = 6,
   parameter int WIDTH   = SIG + INT + FLT,
   parameter int N       = 64,
   parameter int NBLK    = 4,
   parameter int TW_W    = 9,
   parameter int TW_FRAC = 7,
   localparam int IW     = WIDTH + 1,
   localparam int BW     = $clog2(NBLK)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 frame_start,
   input  logic                 din_valid,
   input  logic signed [IW-1:0] din_re [16],
   input  logic signed [IW-1:0] din_im [16],
   input  logic                 ovf_clr,
   output logic                 dout_valid,
   output logic signed [IW-1:0] dout_re [16],
   output logic signed [IW-1:0] dout_im [16],
   output logic [BW-1:0]        dout_blk,
   output logic                 ovf_sticky
);
   localparam int E_W = $clog2(N);
   localparam int PW  = IW + TW_W;
   localparam int SW  = PW + 1;
   localparam logic signed [SW-1:0] RND_HALF = SW'(2 ** (TW_FRAC - 1));
   localparam logic signed [SW-1:0] SAT_MAX  = SW'(2 ** (IW - 1) - 1);
   localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;

   // First-quadrant cosine table: round(128*cos(2*pi*r/64)), r = 0..16
   function automatic logic signed [TW_W-1:0] tw_q(input logic [4:0] r);
      case (r)
         5'd0:    tw_q = TW_W'(128);
         5'd1:    tw_q = TW_W'(127);
         5'd2:    tw_q = TW_W'(126);
         5'd3:    tw_q = TW_W'(122);
         5'd4:    tw_q = TW_W'(118);
         5'd5:    tw_q = TW_W'(113);
         5'd6:    tw_q = TW_W'(106);
         5'd7:    tw_q = TW_W'(99);
         5'd8:    tw_q = TW_W'(91);
         5'd9:    tw_q = TW_W'(81);
         5'd10:   tw_q = TW_W'(71);
         5'd11:   tw_q = TW_W'(60);
         5'd12:   tw_q = TW_W'(49);
         5'd13:   tw_q = TW_W'(37);
         5'd14:   tw_q = TW_W'(25);
         5'd15:   tw_q = TW_W'(13);
         default: tw_q = '0;
      endcase
   endfunction

   function automatic logic signed [TW_W-1:0] tw_cos(input logic [E_W-1:0] e);
      logic [4:0] r;
      r = {1'b0, e[3:0]};
      case (e[5:4])
         2'd0:    tw_cos = tw_q(r);
         2'd1:    tw_cos = -tw_q(5'd16 - r);
         2'd2:    tw_cos = -tw_q(r);
         default: tw_cos = tw_q(5'd16 - r);
      endcase
   endfunction

   function automatic logic signed [TW_W-1:0] tw_sin(input logic [E_W-1:0] e);
      logic [4:0] r;
      r = {1'b0, e[3:0]};
      case (e[5:4])
         2'd0:    tw_sin = tw_q(5'd16 - r);
         2'd1:    tw_sin = tw_q(r);
         2'd2:    tw_sin = -tw_q(5'd16 - r);
         default: tw_sin = -tw_q(r);
      endcase
   endfunction

   function automatic logic signed [SW-1:0] rnd(input logic signed [SW-1:0] x);
      logic signed [SW-1:0] t;
      t = x + RND_HALF;
      return t >>> TW_FRAC;
   endfunction

   function automatic logic is_sat(input logic signed [SW-1:0] x);
      return (x > SAT_MAX) || (x < SAT_MIN);
   endfunction

   function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] x);
      if (x > SAT_MAX)      return {1'b0, {(IW-1){1'b1}}};
      else if (x < SAT_MIN) return {1'b1, {(IW-1){1'b0}}};
      else                  return x[IW-1:0];
   endfunction

   logic [BW-1:0]        r_blk;
   logic [BW-1:0]        w_blk_use;
   logic                 r_vld_p0, r_vld_p1;
   logic [BW-1:0]        r_blk_p0, r_blk_p1;
   logic signed [IW-1:0] r_re_p0 [16];
   logic signed [IW-1:0] r_im_p0 [16];
   logic signed [TW_W-1:0] w_wre [16];
   logic signed [TW_W-1:0] w_wim [16];
   logic signed [PW-1:0] r_ac_p1 [16];
   logic signed [PW-1:0] r_bd_p1 [16];
   logic signed [PW-1:0] r_ad_p1 [16];
   logic signed [PW-1:0] r_bc_p1 [16];
   logic signed [SW-1:0] w_sre [16];
   logic signed [SW-1:0] w_sim [16];
   logic                 w_any_sat;

   assign w_blk_use = frame_start ? '0 : r_blk;

   // Stage 0: capture beat and the block index it will use
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_blk    <= '0;
         r_vld_p0 <= 1'b0;
         r_blk_p0 <= '0;
         for (int i = 0; i < 16; i++) begin
            r_re_p0[i] <= '0;
            r_im_p0[i] <= '0;
         end
      end else begin
         if (din_valid) r_blk <= w_blk_use + BW'(1);
         r_vld_p0 <= din_valid;
         r_blk_p0 <= w_blk_use;
         r_re_p0  <= din_re;
         r_im_p0  <= din_im;
      end
   end

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_wre[i] = tw_cos(E_W'(i * int'(r_blk_p0)));
         w_wim[i] = -tw_sin(E_W'(i * int'(r_blk_p0)));
      end
   end

   // Stage 1: full-precision partial products
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_vld_p1 <= 1'b0;
         r_blk_p1 <= '0;
         for (int i = 0; i < 16; i++) begin
            r_ac_p1[i] <= '0;
            r_bd_p1[i] <= '0;
            r_ad_p1[i] <= '0;
            r_bc_p1[i] <= '0;
         end
      end else begin
         r_vld_p1 <= r_vld_p0;
         r_blk_p1 <= r_blk_p0;
         for (int i = 0; i < 16; i++) begin
            r_ac_p1[i] <= PW'(r_re_p0[i]) * PW'(w_wre[i]);
            r_bd_p1[i] <= PW'(r_im_p0[i]) * PW'(w_wim[i]);
            r_ad_p1[i] <= PW'(r_re_p0[i]) * PW'(w_wim[i]);
            r_bc_p1[i] <= PW'(r_im_p0[i]) * PW'(w_wre[i]);
         end
      end
   end

   always_comb begin
      w_any_sat = 1'b0;
      for (int i = 0; i < 16; i++) begin
         w_sre[i] = rnd(SW'(r_ac_p1[i]) - SW'(r_bd_p1[i]));
         w_sim[i] = rnd(SW'(r_ad_p1[i]) + SW'(r_bc_p1[i]));
         if (is_sat(w_sre[i]) || is_sat(w_sim[i])) w_any_sat = 1'b1;
      end
   end

   // Stage 2: round, saturate, register outputs (held while not valid)
   always_ff @(posedge clk) begin
      if (rstn) begin
         dout_valid <= 1'b0;
         dout_blk   <= '0;
         ovf_sticky <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            dout_re[i] <= '0;
            dout_im[i] <= '0;
         end
      end else begin
         dout_valid <= r_vld_p1;
         if (r_vld_p1) begin
            dout_blk <= r_blk_p1;
            for (int i = 0; i < 16; i++) begin
               dout_re[i] <= sat(w_sre[i]);
               dout_im[i] <= sat(w_sim[i]);
            end
         end
         if (r_vld_p1 && w_any_sat) ovf_sticky <= 1'b1;
         else if (ovf_clr)          ovf_sticky <= 1'b0;
      end
   end
endmodule

// File: tb/tb_bfly_twiddle_mul.sv
// Directed bench for bfly_twiddle_mul: identity, -j, 45 deg, saturation,
// block counter wrap/frame_start, and reset with a beat in flight.
module tb_bfly_twiddle_mul;
   logic               clk = 1'b0;
   logic               rstn;
   logic               frame_start;
   logic               din_valid;
   logic signed [10:0] din_re [16];
   logic signed [10:0] din_im [16];
   logic               ovf_clr;
   logic               dout_valid;
   logic signed [10:0] dout_re [16];
   logic signed [10:0] dout_im [16];
   logic [1:0]         dout_blk;
   logic               ovf_sticky;

   int checks = 0;
   int errors = 0;

   bfly_twiddle_mul dut (
      .clk(clk), .rstn(rstn), .frame_start(frame_start), .din_valid(din_valid),
      .din_re(din_re), .din_im(din_im), .ovf_clr(ovf_clr),
      .dout_valid(dout_valid), .dout_re(dout_re), .dout_im(dout_im),
      .dout_blk(dout_blk), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < 16; i++) begin
         din_re[i] = '0;
         din_im[i] = '0;
      end
   endtask

   task automatic idle();
      din_valid   = 1'b0;
      frame_start = 1'b0;
      clear_lanes();
   endtask

   task automatic test_reset();
      rstn = 1'b1; ovf_clr = 1'b0;
      idle();
      tick(); tick();
      rstn = 1'b0;
      checks++;
      if (dout_valid !== 1'b0 || dout_blk !== 2'd0 || ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got valid=%b blk=%0d ovf=%b expected 0 0 0", dout_valid, dout_blk, ovf_sticky);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dout_re[i] !== 11'sd0 || dout_im[i] !== 11'sd0) begin
            errors++;
            $display("FAIL reset_data lane %0d: got %0d,%0d expected 0,0", i, dout_re[i], dout_im[i]);
         end
      end
   endtask

   task automatic test_identity();
      frame_start = 1'b1; din_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din_re[i] = 11'sd100;
         din_im[i] = -11'sd40;
      end
      tick();
      idle();
      tick();
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL id_early_valid: got %b expected 0", dout_valid);
      end
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== 2'd0) begin
         errors++;
         $display("FAIL id_valid_blk: got valid=%b blk=%0d expected 1 0", dout_valid, dout_blk);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dout_re[i] !== 11'sd100 || dout_im[i] !== -11'sd40) begin
            errors++;
            $display("FAIL id_lane %0d: got %0d,%0d expected 100,-40", i, dout_re[i], dout_im[i]);
         end
      end
      tick();
      checks++;
      if (dout_valid !== 1'b0 || dout_re[3] !== 11'sd100 || dout_im[3] !== -11'sd40) begin
         errors++;
         $display("FAIL id_hold: got valid=%b %0d,%0d expected 0 100,-40", dout_valid, dout_re[3], dout_im[3]);
      end
   endtask

   // Counter is now 1 (after the identity beat), so this beat is blk 1
   task automatic test_twiddle45();
      din_valid = 1'b1;
      din_re[8] = 11'sd100; din_im[8] = 11'sd0;
      din_re[0] = 11'sd20;  din_im[0] = 11'sd7;
      tick();
      idle();
      tick(); tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== 2'd1) begin
         errors++;
         $display("FAIL w45_valid_blk: got valid=%b blk=%0d expected 1 1", dout_valid, dout_blk);
      end
      checks++;
      if (dout_re[8] !== 11'sd71 || dout_im[8] !== -11'sd71) begin
         errors++;
         $display("FAIL w45_lane8: got %0d,%0d expected 71,-71", dout_re[8], dout_im[8]);
      end
      checks++;
      if (dout_re[0] !== 11'sd20 || dout_im[0] !== 11'sd7) begin
         errors++;
         $display("FAIL w45_lane0: got %0d,%0d expected 20,7", dout_re[0], dout_im[0]);
      end
      tick();
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL w45_ovf: got %b expected 0", ovf_sticky);
      end
   endtask

   // Idle gaps above must not have advanced the counter: this beat is blk 2
   task automatic test_minus_j();
      din_valid = 1'b1;
      din_re[8] = 11'sd50; din_im[8] = -11'sd30;
      tick();
      idle();
      tick(); tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== 2'd2) begin
         errors++;
         $display("FAIL mj_valid_blk: got valid=%b blk=%0d expected 1 2", dout_valid, dout_blk);
      end
      checks++;
      if (dout_re[8] !== -11'sd30 || dout_im[8] !== -11'sd50) begin
         errors++;
         $display("FAIL mj_lane8: got %0d,%0d expected -30,-50", dout_re[8], dout_im[8]);
      end
   endtask

   task automatic test_saturation();
      frame_start = 1'b1; din_valid = 1'b1;
      tick();
      frame_start = 1'b0;
      din_re[8] = 11'sd1023; din_im[8] = 11'sd1023;
      tick();
      idle();
      tick(); tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== 2'd1) begin
         errors++;
         $display("FAIL sat_valid_blk: got valid=%b blk=%0d expected 1 1", dout_valid, dout_blk);
      end
      checks++;
      if (dout_re[8] !== 11'sd1023 || dout_im[8] !== 11'sd0) begin
         errors++;
         $display("FAIL sat_lane8: got %0d,%0d expected 1023,0", dout_re[8], dout_im[8]);
      end
      tick();
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL sat_ovf_set: got %b expected 1", ovf_sticky);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL sat_ovf_clr: got %b expected 0", ovf_sticky);
      end
   endtask

   task automatic test_back_to_back();
      int exp_blk [6] = '{0, 1, 2, 3, 0, 0};
      for (int t = 0; t < 8; t++) begin
         if (t < 6) begin
            din_valid   = 1'b1;
            frame_start = (t == 0 || t == 5);
            din_re[0]   = 11'(t * 10);
            din_im[0]   = -11'(t);
         end else begin
            idle();
         end
         tick();
         if (t >= 2) begin
            checks++;
            if (dout_valid !== 1'b1 || int'(dout_blk) != exp_blk[t-2] ||
                dout_re[0] !== 11'((t - 2) * 10) || dout_im[0] !== -11'(t - 2)) begin
               errors++;
               $display("FAIL b2b beat %0d: got valid=%b blk=%0d re=%0d im=%0d expected 1 %0d %0d %0d",
                        t - 2, dout_valid, dout_blk, dout_re[0], dout_im[0],
                        exp_blk[t-2], (t - 2) * 10, -(t - 2));
            end
         end
      end
      tick(); tick();
      din_valid = 1'b1;
      tick();
      idle();
      tick(); tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== 2'd1) begin
         errors++;
         $display("FAIL gap_blk: got valid=%b blk=%0d expected 1 1", dout_valid, dout_blk);
      end
   endtask

   task automatic test_reset_midflight();
      din_valid = 1'b1;
      din_re[0] = 11'sd77; din_im[0] = 11'sd33;
      tick();
      idle();
      rstn = 1'b1;
      tick();
      rstn = 1'b0;
      for (int t = 0; t < 3; t++) begin
         checks++;
         if (dout_valid !== 1'b0 || dout_re[0] !== 11'sd0 || dout_im[0] !== 11'sd0 ||
             dout_blk !== 2'd0 || ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL rst_flight cyc %0d: got valid=%b re=%0d im=%0d blk=%0d ovf=%b expected all 0",
                     t, dout_valid, dout_re[0], dout_im[0], dout_blk, ovf_sticky);
         end
         tick();
      end
      din_valid = 1'b1;
      din_re[1] = 11'sd5; din_im[1] = 11'sd6;
      tick();
      idle();
      tick(); tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_blk !== 2'd0 || dout_re[1] !== 11'sd5 || dout_im[1] !== 11'sd6) begin
         errors++;
         $display("FAIL rst_restart: got valid=%b blk=%0d %0d,%0d expected 1 0 5,6",
                  dout_valid, dout_blk, dout_re[1], dout_im[1]);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_twiddle45();
      test_minus_j();
      test_saturation();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
